ccff_chain_loader: RTL and testbench
====================================

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 8: number of configuration flops in the downstream ccff chain; legal range is 1 or more.
REQ-002 Parameter WORD_W, default 8: width of the bitstream word interfaces.
REQ-003 prog_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 pReset  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  begin a load; sampled only in IDLE.
REQ-006 abort  input  1  cancel the current load; sampled in any state other than IDLE.
REQ-007 wr_data  input  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
REQ-008 wr_valid  input  1  wr_data is valid.
REQ-009 wr_ready  output  1  loader accepts wr_data this cycle.
REQ-010 ccff_head  output  1  serial configuration bit driven into the chain head (registered).
REQ-011 ccff_clk_en  output  1  gating enable for the chain's prog_clk (registered); the chain captures ccff_head on every edge that ends a cycle with ccff_clk_en=1.
REQ-012 ccff_tail  input  1  serial bit from the chain tail (previous contents).
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 rd_data  output  WORD_W  captured readback word; the first captured bit is placed in the MSB.
REQ-016 rd_valid  output  1  one-cycle pulse qualifying rd_data; there is no backpressure.

Function
REQ-017 The loader SHALL implement the states IDLE, FETCH, SHIFT and DONE.
REQ-018 IDLE→FETCH on start=1: load the bits-remaining counter with CHAIN_LEN and clear the readback shift register and readback bit count.
REQ-019 FETCH: wr_ready=1 combinationally; when wr_valid=1, latch wr_data into the shift register and set the word-bit counter to min(WORD_W, bits remaining); go to SHIFT.
REQ-020 SHIFT, each cycle: register ccff_head<=sreg[WORD_W-1] and ccff_clk_en<=1, shift sreg left by one, decrement both counters.
REQ-021 On the last bit of a word, if bits remain go to FETCH; if none remain go to DONE. There is exactly one ccff_clk_en=0 bubble per FETCH cycle.
REQ-022 While stalled in FETCH (wr_valid=0), ccff_clk_en SHALL be 0 and ccff_head SHALL hold its value.
REQ-023 Exactly CHAIN_LEN cycles with ccff_clk_en=1 SHALL occur per completed load. In the final word only the top (CHAIN_LEN mod WORD_W) bits are used when that value is nonzero; the remaining bits are discarded.
REQ-024 Readback: on each edge ending a cycle with ccff_clk_en=1, shift ccff_tail into the readback register. Every WORD_W captured bits, pulse rd_valid for one cycle with the full word.
REQ-025 DONE lasts one cycle, which is the cycle after the final ccff_clk_en=1 cycle. In DONE: done=1, and if a partial readback word is pending, rd_valid=1 with rd_data left-justified and LSBs zero-padded. Then return to IDLE.
REQ-026 abort=1 in FETCH, SHIFT or DONE: next state IDLE, ccff_clk_en<=0, no done pulse, partial readback discarded. Abort takes priority over every other event in the same cycle.
REQ-027 start while busy=1 SHALL be ignored. A wr_valid presented outside FETCH SHALL NOT be consumed.

Reset
REQ-028 pReset=1 SHALL immediately force IDLE and set ccff_head=0, ccff_clk_en=0, wr_ready=0, busy=0, done=0, rd_valid=0, rd_data=0, and clear all counters. This applies mid-shift.
REQ-029 After pReset deasserts, the loader SHALL remain in IDLE until the first start.

Verification
REQ-030 CHAIN_LEN=8, WORD_W=8, chain preloaded with 0x3C: start, word 0xA5 → ccff_head sequence 1,0,1,0,0,1,0,1 over 8 consecutive enabled cycles; rd_valid with rd_data=0x3C; done one cycle after the last enabled cycle.
REQ-031 CHAIN_LEN=12, WORD_W=8, chain previously loaded with F,0,A (nibbles, MSB-first): words 0xF0 and 0xAB → 12 enabled cycles carrying 0xF0 then 0xA; rd_valid 0xF0, then 0xA0 in the DONE cycle.
REQ-032 wr_valid held low for 5 cycles between words → ccff_clk_en=0 for 6 cycles with ccff_head held; the total enabled count is still CHAIN_LEN.
REQ-033 pReset pulsed after 3 enabled cycles → all outputs 0 in the same cycle; a following start reloads the full CHAIN_LEN bits.
REQ-034 abort in SHIFT after 5 bits → ccff_clk_en=0 next cycle, no done, no rd_valid; start asserted mid-load beforehand was ignored.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// Streams bitstream words MSB-first into a serial configuration-flop chain.
// Captures the bits that fall out of the chain tail into readback words.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 8,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid
);

  localparam int MAX_N = (CHAIN_LEN > WORD_W) ? CHAIN_LEN : WORD_W;
  localparam int CNT_W = $clog2(MAX_N + 1);
  localparam logic [CNT_W-1:0] CHAIN_CNT = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] WORD_CNT  = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHIFT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [WORD_W-1:0] rb_q, rb_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;
  logic [CNT_W-1:0]  bits_rem_q, bits_rem_d;
  logic [CNT_W-1:0]  wbits_q, wbits_d;
  logic [CNT_W-1:0]  rb_cnt_q, rb_cnt_d;
  logic              head_q, head_d;
  logic              en_q, en_d;
  logic              done_q, done_d;
  logic              rd_valid_q, rd_valid_d;
  logic [WORD_W-1:0] rb_shift;
  logic [CNT_W-1:0]  rb_cnt_inc;

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    rb_d       = rb_q;
    rd_data_d  = rd_data_q;
    bits_rem_d = bits_rem_q;
    wbits_d    = wbits_q;
    rb_cnt_d   = rb_cnt_q;
    head_d     = head_q;
    en_d       = 1'b0;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    wr_ready   = 1'b0;
    rb_shift   = (rb_q << 1) | WORD_W'(ccff_tail);
    rb_cnt_inc = rb_cnt_q + ONE;

    // The chain captures on every enabled cycle, so readback follows en_q, not state.
    if (en_q) begin
      if (rb_cnt_inc == WORD_CNT) begin
        rd_data_d  = rb_shift;
        rd_valid_d = 1'b1;
        rb_d       = '0;
        rb_cnt_d   = '0;
      end else begin
        rb_d     = rb_shift;
        rb_cnt_d = rb_cnt_inc;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FETCH;
          bits_rem_d = CHAIN_CNT;
          wbits_d    = '0;
          rb_d       = '0;
          rb_cnt_d   = '0;
        end
      end
      S_FETCH: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          sreg_d  = wr_data;
          wbits_d = (bits_rem_q < WORD_CNT) ? bits_rem_q : WORD_CNT;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        head_d     = sreg_q[WORD_W-1];
        en_d       = 1'b1;
        sreg_d     = sreg_q << 1;
        wbits_d    = wbits_q - ONE;
        bits_rem_d = bits_rem_q - ONE;
        if (wbits_q == ONE)
          state_d = (bits_rem_q == ONE) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        // This is the final enabled cycle; its tail bit is already folded into rb_d.
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (rb_cnt_d != '0) begin
          rd_valid_d = 1'b1;
          rd_data_d  = rb_d << (WORD_CNT - rb_cnt_d);
          rb_d       = '0;
          rb_cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      wr_ready   = 1'b0;
      sreg_d     = sreg_q;
      head_d     = head_q;
      en_d       = 1'b0;
      done_d     = 1'b0;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      rb_d       = '0;
      rb_cnt_d   = '0;
    end
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q    <= S_IDLE;
      sreg_q     <= '0;
      rb_q       <= '0;
      rd_data_q  <= '0;
      bits_rem_q <= '0;
      wbits_q    <= '0;
      rb_cnt_q   <= '0;
      head_q     <= 1'b0;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      rb_q       <= rb_d;
      rd_data_q  <= rd_data_d;
      bits_rem_q <= bits_rem_d;
      wbits_q    <= wbits_d;
      rb_cnt_q   <= rb_cnt_d;
      head_q     <= head_d;
      en_q       <= en_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign ccff_head   = head_q;
  assign ccff_clk_en = en_q;
  assign done        = done_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader with a behavioural chain model on the serial port.
module tb_ccff_chain_loader;
  localparam int CL = 12;
  localparam int W  = 8;
  localparam int NW = (CL + W - 1) / W;

  logic         prog_clk = 1'b0;
  logic         pReset   = 1'b1;
  logic         start    = 1'b0;
  logic         abort    = 1'b0;
  logic [W-1:0] wr_data  = '0;
  logic         wr_valid = 1'b0;
  logic         wr_ready, ccff_head, ccff_clk_en, ccff_tail, busy, done, rd_valid;
  logic [W-1:0] rd_data;

  logic [CL-1:0] chain_m = 12'h3C5;

  int   errors = 0, checks = 0;
  logic         exp_head_q[$];
  logic [W-1:0] exp_rd_q[$];
  int           exp_gap_q[$];
  int   exp_done = 0, en_cnt = 0, done_cnt = 0, zrun = 0;
  bit   seen_en = 1'b0;
  logic prev_head = 1'b0, prev_en = 1'b0;
  logic [W-1:0] wbuf[NW];
  int           gap[NW];

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(W)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .start(start), .abort(abort),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .ccff_head(ccff_head), .ccff_clk_en(ccff_clk_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 prog_clk = ~prog_clk;

  // Downstream chain: shifts head in on every enabled edge, oldest bit exits at the tail.
  assign ccff_tail = chain_m[CL-1];
  always @(posedge prog_clk) if (ccff_clk_en) chain_m <= {chain_m[CL-2:0], ccff_head};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  always @(negedge prog_clk) begin
    if (pReset) begin
      prev_head = 1'b0;
      prev_en   = 1'b0;
      zrun      = 0;
    end else begin
      if (ccff_clk_en) begin
        if (exp_head_q.size() == 0) fail("enable", "got ccff_clk_en=1 expected 0");
        else chk("ccff_head", 32'(ccff_head), 32'(exp_head_q.pop_front()));
        if (seen_en && zrun > 0) begin
          if (exp_gap_q.size() == 0) fail("bubble_len", "got extra bubble expected none");
          else chk("bubble_len", 32'(zrun), 32'(exp_gap_q.pop_front()));
        end
        seen_en = 1'b1;
        zrun    = 0;
        en_cnt++;
      end else begin
        chk("head_hold", 32'(ccff_head), 32'(prev_head));
        zrun++;
      end
      if (rd_valid) begin
        if (exp_rd_q.size() == 0) fail("rd_valid", "got rd_valid=1 expected 0");
        else chk("rd_data", 32'(rd_data), 32'(exp_rd_q.pop_front()));
      end
      if (done) begin
        if (exp_done == 0) fail("done", "got done=1 expected 0");
        else begin
          exp_done--;
          chk("done_after_last_en", 32'(prev_en), 32'd1);
          chk("done_en_count", 32'(en_cnt), 32'(CL));
        end
        done_cnt++;
      end
      prev_head = ccff_head;
      prev_en   = ccff_clk_en;
    end
  end

  task automatic flush();
    exp_head_q.delete();
    exp_rd_q.delete();
    exp_gap_q.delete();
    exp_done = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_head"},     32'(ccff_head),   32'd0);
    chk({tag, "_clk_en"},   32'(ccff_clk_en), 32'd0);
    chk({tag, "_wr_ready"}, 32'(wr_ready),    32'd0);
    chk({tag, "_busy"},     32'(busy),        32'd0);
    chk({tag, "_done"},     32'(done),        32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid),    32'd0);
    chk({tag, "_rd_data"},  32'(rd_data),     32'd0);
  endtask

  task automatic begin_load(input bit start_mid);
    int rem;
    int n;
    logic [W-1:0] acc;
    rem = CL;
    for (int w = 0; w < NW; w++)
      for (int b = 0; b < W; b++)
        if (rem > 0) begin
          exp_head_q.push_back(wbuf[w][W-1-b]);
          rem--;
        end
    for (int w = 1; w < NW; w++) exp_gap_q.push_back((gap[w] < 0) ? 1 : gap[w] + 1);
    // Readback is the old chain contents, deepest bit first, chunked into words.
    acc = '0;
    n   = 0;
    for (int k = 0; k < CL; k++) begin
      acc = {acc[W-2:0], chain_m[CL-1-k]};
      n++;
      if (n == W) begin
        exp_rd_q.push_back(acc);
        acc = '0;
        n   = 0;
      end
    end
    if (n > 0) exp_rd_q.push_back(acc << (W - n));
    exp_done++;
    en_cnt  = 0;
    seen_en = 1'b0;
    @(posedge prog_clk); #1 start = 1'b1;
    @(posedge prog_clk); #1 start = 1'b0;
    if (start_mid) begin
      @(posedge prog_clk); #1 start = 1'b1;
      @(posedge prog_clk); #1 start = 1'b0;
    end
  endtask

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge prog_clk);
      if (wr_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("wr_ready_timeout", "got no wr_ready expected one within 100 cycles");
  endtask

  task automatic feed_word(input int i);
    if (gap[i] < 0) begin
      wr_data  = wbuf[i];
      wr_valid = 1'b1;
    end
    wait_ready();
    if (gap[i] > 0) begin
      repeat (gap[i]) @(posedge prog_clk);
      #1;
    end else if (gap[i] == 0) #1;
    wr_data  = wbuf[i];
    wr_valid = 1'b1;
    @(posedge prog_clk); #1;
    wr_valid = 1'b0;
    wr_data  = W'($urandom);
  endtask

  task automatic wait_done();
    int c0 = done_cnt;
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge prog_clk);
      if (done_cnt != c0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("done_timeout", "got no done expected one within 100 cycles");
  endtask

  task automatic wait_en(input int n);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge prog_clk);
      if (en_cnt >= n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("enable_timeout", "got too few enabled cycles expected more within 200");
  endtask

  task automatic run_load(input bit start_mid);
    begin_load(start_mid);
    for (int i = 0; i < NW; i++) feed_word(i);
    wait_done();
  endtask

  initial begin
    repeat (2) @(posedge prog_clk);
    #1 check_all_zero("reset");
    @(posedge prog_clk); #1 pReset = 1'b0;
    repeat (4) @(negedge prog_clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_clk_en", 32'(ccff_clk_en), 32'd0);

    // Two identical loads: the second reads back F0 then A0.
    for (int r = 0; r < 2; r++) begin
      wbuf[0] = 8'hF0; wbuf[1] = 8'hAB;
      gap[0]  = 0;     gap[1]  = -1;
      run_load(1'b0);
    end
    chk("chain_after_f0ab", 32'(chain_m), 32'h0F0A);

    // Five-cycle stall between words, with an ignored start during FETCH.
    wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
    gap[0]  = 1;     gap[1]  = 5;
    run_load(1'b1);

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NW; i++) begin
        wbuf[i] = W'($urandom);
        gap[i]  = int'($urandom_range(0, 4)) - 1;
      end
      run_load(1'($urandom_range(0, 1)));
    end

    // Abort part way through the first word; a start pulse in SHIFT is ignored.
    wbuf[0] = W'($urandom); wbuf[1] = W'($urandom);
    gap[0]  = 0;            gap[1]  = 0;
    begin_load(1'b0);
    feed_word(0);
    wait_en(2);
    @(posedge prog_clk); #1 start = 1'b1;
    @(posedge prog_clk); #1 start = 1'b0;
    wait_en(5);
    @(posedge prog_clk); #1 abort = 1'b1;
    @(posedge prog_clk); #1 abort = 1'b0;
    flush();
    @(negedge prog_clk);
    chk("abort_clk_en", 32'(ccff_clk_en), 32'd0);
    chk("abort_busy",   32'(busy),        32'd0);
    chk("abort_done",   32'(done),        32'd0);
    chk("abort_rd",     32'(rd_valid),    32'd0);
    repeat (5) @(negedge prog_clk);

    // Asynchronous reset after three enabled cycles, then a full reload.
    wbuf[0] = W'($urandom); wbuf[1] = W'($urandom);
    begin_load(1'b0);
    feed_word(0);
    wait_en(3);
    @(posedge prog_clk); #1 pReset = 1'b1;
    #1 check_all_zero("mid_reset");
    flush();
    @(posedge prog_clk); #1 pReset = 1'b0;
    repeat (3) @(negedge prog_clk);
    chk("post_reset_busy", 32'(busy), 32'd0);
    wbuf[0] = W'($urandom); wbuf[1] = W'($urandom);
    gap[0]  = 2;            gap[1]  = 0;
    run_load(1'b0);

    repeat (4) @(negedge prog_clk);
    chk("left_head", 32'(exp_head_q.size()), 32'd0);
    chk("left_rd",   32'(exp_rd_q.size()),   32'd0);
    chk("left_gap",  32'(exp_gap_q.size()),  32'd0);
    chk("left_done", 32'(exp_done),          32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end
endmodule
